eth_frame_packager: RTL

Parametrised Ethernet TX framer. Buffers one payload frame from the byte-wide upstream and emits preamble, SFD, MAC header, payload and zero padding as a continuous MSB-first lane stream (dibits at OUT_W=2). Sits between the encoder byte output and the bit-order / FCS stage. Adds three things: explicit frame delimiting, minimum-length padding, and overflow drop. Enforces an inter-frame gap.

---
 rtl/eth_pkg.sv | 31 +++
 rtl/eth_payload_ram.sv | 33 +++
 rtl/eth_frame_packager.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet TX framer.
// Holds the framer state encoding, the fixed header layout and a helper
// that turns the output lane width into lanes per byte.
package eth_pkg;

    // Framer states, in the order a frame passes through them.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PAD     = 3'd3,
        ST_GAP     = 3'd4
    } eth_state_t;

    // Header layout: 7 preamble bytes, SFD, 6+6 address bytes, 2 ethertype bytes.
    localparam int         PREAMBLE_BYTES = 7;
    localparam logic [7:0] PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0] SFD            = 8'hD5;
    localparam int         HDR_BYTES      = 22;

    // First header byte index of each header field.
    localparam int DA_FIRST = PREAMBLE_BYTES + 1;
    localparam int SA_FIRST = DA_FIRST + 6;
    localparam int ET_FIRST = SA_FIRST + 6;

    // Number of output lanes needed to carry one byte.
    function automatic int lanes_per_byte(input int out_w);
        return 8 / out_w;
    endfunction

endpackage

// File: rtl/eth_payload_ram.sv
// Simple dual-port payload buffer, one write port and one read port.
// Read data is registered (1-cycle latency) and only updates when rd_en is
// high, so the current byte stays stable while its lanes are shifted out.
module eth_payload_ram #(
    parameter int DEPTH  = 1500,
    parameter int ADDR_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [0:DEPTH-1];

    // Write port: store one payload byte per accepted upstream beat.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered read, held between enables.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/eth_frame_packager.sv
// Ethernet TX framer: buffers one payload frame from a byte-wide upstream,
// then emits preamble, SFD, MAC header, payload and zero padding as a
// continuous MSB-first lane stream, followed by an inter-frame gap.
// Frames longer than MAX_PAYLOAD are discarded and flagged on drop.
//
// Upstream handshake: a byte transfers on a rising edge where
// valid_in && ready_out. ready_out is high only in IDLE and does not depend
// on valid_in; last_in is only meaningful on a transferring beat.
// Downstream: axiov/axiod carry no backpressure; axiov stays high for the
// whole header+payload+pad burst.
module eth_frame_packager
    import eth_pkg::*;
#(
    parameter int          OUT_W       = 2,
    parameter int          MAX_PAYLOAD = 1500,
    parameter int          MIN_PAYLOAD = 46,
    parameter int          IFG_BYTES   = 12,
    parameter logic [47:0] DEST_ADDR   = 48'hF00DDEADBEEF,
    parameter logic [47:0] SRC_ADDR    = 48'hF00DDEADBEEF,
    parameter logic [15:0] ETHERTYPE   = 16'h0800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [7:0]       byte_in,
    input  logic             last_in,
    output logic             ready_out,
    output logic             axiov,
    output logic [OUT_W-1:0] axiod,
    output logic             drop,
    output eth_state_t       state_dbg
);

    localparam int                LPB       = lanes_per_byte(OUT_W);
    localparam int                LANE_W    = (LPB > 1) ? $clog2(LPB) : 1;
    localparam int                ADDR_W    = $clog2(MAX_PAYLOAD + 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LPB - 1);

    eth_state_t state, state_nxt;

    logic [ADDR_W-1:0] wr_cnt;     // payload write address / bytes buffered
    logic [ADDR_W-1:0] len;        // committed payload length
    logic [ADDR_W-1:0] byte_idx;   // byte position inside the current state
    logic [LANE_W-1:0] lane_cnt;   // lane position inside the current byte
    logic              ovf;        // current upstream frame exceeded the buffer

    logic              accept;
    logic              full;
    logic              wr_en;
    logic              commit;
    logic              discard;
    logic              lane_last;
    logic              hdr_done;
    logic              pay_done;
    logic              pad_done;
    logic              gap_done;
    logic              need_pad;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [7:0]        hdr_byte;
    logic [7:0]        lane_byte;
    logic [7:0]        lane_shift;
    int                hdr_idx;

    assign state_dbg = state;

    // Upstream acceptance, overflow detection and per-state end-of-phase flags.
    always_comb begin
        accept    = valid_in && (state == ST_IDLE);
        full      = (wr_cnt == ADDR_W'(MAX_PAYLOAD));
        wr_en     = accept && !ovf && !full;
        commit    = accept && last_in && !ovf && !full;
        discard   = accept && last_in && (ovf || full);
        lane_last = (lane_cnt == LANE_LAST);
        hdr_done  = (byte_idx == ADDR_W'(HDR_BYTES - 1));
        pay_done  = (byte_idx == len - 1'b1);
        pad_done  = (byte_idx == ADDR_W'(MIN_PAYLOAD - 1));
        gap_done  = (byte_idx == ADDR_W'(IFG_BYTES - 1));
        need_pad  = (len < ADDR_W'(MIN_PAYLOAD));
    end

    // Header byte mux: picks the field byte for the current header index.
    always_comb begin
        hdr_idx  = int'(byte_idx);
        hdr_byte = PREAMBLE_BYTE;
        if (hdr_idx == PREAMBLE_BYTES) begin
            hdr_byte = SFD;
        end else if (hdr_idx >= DA_FIRST && hdr_idx < SA_FIRST) begin
            hdr_byte = DEST_ADDR[8 * (SA_FIRST - 1 - hdr_idx) +: 8];
        end else if (hdr_idx >= SA_FIRST && hdr_idx < ET_FIRST) begin
            hdr_byte = SRC_ADDR[8 * (ET_FIRST - 1 - hdr_idx) +: 8];
        end else if (hdr_idx >= ET_FIRST && hdr_idx < HDR_BYTES) begin
            hdr_byte = ETHERTYPE[8 * (HDR_BYTES - 1 - hdr_idx) +: 8];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode. Buffer reads are issued on the last lane
    // of the preceding byte so rd_data is ready exactly when the byte starts.
    always_comb begin
        state_nxt = state;
        ready_out = 1'b0;
        axiov     = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        lane_byte = 8'h00;
        case (state)
            ST_IDLE: begin
                ready_out = 1'b1;
                if (commit) begin
                    state_nxt = ST_HEADER;
                end
            end
            ST_HEADER: begin
                axiov     = 1'b1;
                lane_byte = hdr_byte;
                if (lane_last && hdr_done) begin
                    rd_en     = 1'b1;
                    rd_addr   = '0;
                    state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                axiov     = 1'b1;
                lane_byte = rd_data;
                if (lane_last) begin
                    if (pay_done) begin
                        state_nxt = need_pad ? ST_PAD : ST_GAP;
                    end else begin
                        rd_en   = 1'b1;
                        rd_addr = byte_idx + 1'b1;
                    end
                end
            end
            ST_PAD: begin
                axiov     = 1'b1;
                lane_byte = 8'h00;
                if (lane_last && pad_done) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (lane_last && gap_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        lane_shift = lane_byte << (int'(lane_cnt) * OUT_W);
        axiod      = lane_shift[7 -: OUT_W];
    end

    // Write-side bookkeeping, byte/lane counters and the drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt   <= '0;
            len      <= '0;
            ovf      <= 1'b0;
            byte_idx <= '0;
            lane_cnt <= '0;
            drop     <= 1'b0;
        end else begin
            drop <= discard;
            case (state)
                ST_IDLE: begin
                    byte_idx <= '0;
                    lane_cnt <= '0;
                    if (wr_en) begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                    if (accept && full && !last_in) begin
                        ovf <= 1'b1;
                    end
                    if (commit) begin
                        len <= wr_cnt + 1'b1;
                    end
                    if (discard) begin
                        wr_cnt <= '0;
                        ovf    <= 1'b0;
                    end
                end
                ST_HEADER, ST_PAYLOAD, ST_PAD, ST_GAP: begin
                    lane_cnt <= lane_last ? '0 : lane_cnt + 1'b1;
                    if (lane_last) begin
                        byte_idx <= byte_idx + 1'b1;
                        if (state == ST_HEADER && hdr_done) begin
                            byte_idx <= '0;
                        end
                        if (state == ST_PAYLOAD && pay_done && !need_pad) begin
                            byte_idx <= '0;
                        end
                        if (state == ST_PAD && pad_done) begin
                            byte_idx <= '0;
                        end
                        if (state == ST_GAP && gap_done) begin
                            byte_idx <= '0;
                            wr_cnt   <= '0;
                        end
                    end
                end
                default: begin
                    byte_idx <= '0;
                    lane_cnt <= '0;
                end
            endcase
        end
    end

    eth_payload_ram #(
        .DEPTH  (MAX_PAYLOAD),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt),
        .wr_data (byte_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
